kt_cpu_core: RTL and testbench

Parametrised, multi-cycle successor to the kt8 accumulator CPU. It keeps the A/B/R register model, the 4-bit ALU op field and the zero-conditioned relative jumps. It adds generic data/address widths, a data-pointer register, a carry flag, a halt state and valid/ready handshakes on separate code and data buses. It sits between the instruction ROM and the data RAM/peripheral bus.

---
 rtl/kt_cpu_core.sv | 138 +++++++++++++
 tb/tb_kt_cpu_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/kt_cpu_core.sv
// kt_cpu_core: multi-cycle accumulator CPU with A/B/R/D registers, carry flag and
// valid/ready handshakes on separate code and data buses.
module kt_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instruction,
    input  logic              code_ready,
    output logic              code_req,
    output logic [ADDR_W-1:0] code_address,
    input  logic [DATA_W-1:0] ram_in,
    input  logic              data_ready,
    output logic              data_req,
    output logic              write,
    output logic [ADDR_W-1:0] data_address,
    output logic [DATA_W-1:0] ram_out,
    output logic              halted
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    localparam logic [3:0] OP_LDA = 4'h1, OP_LDB = 4'h2, OP_LIB = 4'h3, OP_ALU = 4'h4;
    localparam logic [3:0] OP_STR = 4'h5, OP_MVD = 4'h6, OP_ADD = 4'h7, OP_JFZ = 4'h8;
    localparam logic [3:0] OP_JBZ = 4'h9, OP_JF = 4'hA, OP_HLT = 4'hB;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx, d, r_d, imm_a, imm_s;
    logic [7:0]        ir;
    logic [DATA_W-1:0] a, b, r;
    logic              c;
    logic [DATA_W:0]   ax, bx, cx, one, alu_x;
    logic [3:0]        op, imm;
    logic              mem_op, r_zero;

    assign op     = ir[7:4];
    assign imm    = ir[3:0];
    assign mem_op = op == OP_LDA || op == OP_LDB || op == OP_STR;
    assign r_zero = r == '0;
    assign imm_a  = {{(ADDR_W-4){1'b0}}, imm};
    assign imm_s  = {{(ADDR_W-4){imm[3]}}, imm};

    generate
        if (ADDR_W > DATA_W) begin : g_wide
            assign r_d = {{(ADDR_W-DATA_W){1'b0}}, r};
        end else begin : g_narrow
            assign r_d = r[ADDR_W-1:0];
        end
    endgenerate

    // Top bit of alu_x is the new carry/borrow; ops that keep C feed c back in.
    assign ax  = {1'b0, a};
    assign bx  = {1'b0, b};
    assign cx  = {{DATA_W{1'b0}}, c};
    assign one = {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        alu_x = {c, {DATA_W{1'b0}}};
        case (imm)
            4'd0:  alu_x = ax + bx;
            4'd1:  alu_x = ax - bx;
            4'd2:  alu_x = ax + bx + cx;
            4'd3:  alu_x = ax - bx - cx;
            4'd4:  alu_x = {c, a & b};
            4'd5:  alu_x = {c, a | b};
            4'd6:  alu_x = {c, a ^ b};
            4'd7:  alu_x = {c, ~a};
            4'd8:  alu_x = {a, 1'b0};
            4'd9:  alu_x = {a[0], 1'b0, a[DATA_W-1:1]};
            4'd10: alu_x = ax + one;
            4'd11: alu_x = ax - one;
            4'd12: alu_x = {c, a};
            4'd13: alu_x = {c, b};
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            FETCH: state_nx = code_ready ? EXEC : FETCH;
            EXEC: begin
                state_nx = mem_op ? MEM : op == OP_HLT ? HALT : FETCH;
                pc_nx    = mem_op || op == OP_HLT ? pc :
                           op == OP_JF || (op == OP_JFZ && r_zero) ? pc + imm_a :
                           op == OP_JBZ && r_zero ? pc - imm_a : pc + 1'b1;
            end
            MEM: begin
                state_nx = data_ready ? FETCH : MEM;
                pc_nx    = data_ready ? pc + 1'b1 : pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
            ir <= '0;
            a  <= '0;
            b  <= '0;
            r  <= '0;
            d  <= '0;
            c  <= 1'b0;
        end else begin
            pc <= pc_nx;
            case (state)
                FETCH: if (code_ready) ir <= instruction;
                EXEC: case (op)
                    OP_LIB: b <= {{(DATA_W-4){1'b0}}, imm};
                    OP_ALU: {c, r} <= alu_x;
                    OP_MVD: d <= r_d;
                    OP_ADD: d <= d + imm_s;
                    default: ;
                endcase
                MEM: if (data_ready) begin
                    if (op == OP_LDA) a <= ram_in;
                    if (op == OP_LDB) b <= ram_in;
                end
                default: ;
            endcase
        end
    end

    assign code_req     = state == FETCH;
    assign data_req     = state == MEM;
    assign write        = state == MEM && op == OP_STR;
    assign halted       = state == HALT;
    assign code_address = pc;
    assign data_address = d;
    assign ram_out      = r;
endmodule

// File: tb/tb_kt_cpu_core.sv
// tb_kt_cpu_core: directed program run with a fetch/store scoreboard for kt_cpu_core.
module tb_kt_cpu_core;
    logic       clk = 1'b0, rst = 1'b0, code_ready = 1'b0, data_ready = 1'b0;
    logic [7:0] instruction, ram_in = 8'h00;
    logic       code_req, data_req, write, halted;
    logic [7:0] code_address, data_address, ram_out;
    logic [7:0] rom [256];
    logic [15:0] fq [$];
    logic [15:0] sq [$];
    int checks = 0, errors = 0;

    kt_cpu_core #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .code_ready(code_ready),
        .code_req(code_req), .code_address(code_address), .ram_in(ram_in),
        .data_ready(data_ready), .data_req(data_req), .write(write),
        .data_address(data_address), .ram_out(ram_out), .halted(halted)
    );

    always #5 clk = ~clk;
    assign instruction = rom[code_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch(input logic [7:0] a);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            hit = code_req && code_ready && code_address == a;
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL wait_fetch: address %0h never fetched, observed %0h", a, code_address);
        end
    endtask

    // Each completed fetch pops {address, R at fetch time}; each completed store pops {D, R}.
    always @(negedge clk) begin
        if (rst && code_req && code_ready) begin
            checks++;
            assert (fq.size() > 0) else begin
                errors++;
                $error("FAIL fetch_extra: observed fetch of %0h expected none", code_address);
            end
            if (fq.size() > 0) begin
                logic [15:0] e;
                e = fq.pop_front();
                chk("fetch_addr", code_address, e[15:8]);
                chk("fetch_r", ram_out, e[7:0]);
            end
        end
        if (rst && data_req && write && data_ready) begin
            checks++;
            assert (sq.size() > 0) else begin
                errors++;
                $error("FAIL store_extra: observed store to %0h expected none", data_address);
            end
            if (sq.size() > 0) begin
                logic [15:0] e;
                e = sq.pop_front();
                chk("store_addr", data_address, e[15:8]);
                chk("store_data", ram_out, e[7:0]);
            end
        end
    end

    initial begin
        logic [7:0] prog [41] = '{
            8'h35, 8'h4D, 8'h50, 8'h10, 8'h31, 8'h40, 8'h83, 8'hB0, 8'hB0, 8'h20,
            8'h4D, 8'h93, 8'h4E, 8'h90, 8'h4C, 8'h60, 8'h72, 8'h7E, 8'h50, 8'h31,
            8'h41, 8'h42, 8'h43, 8'h48, 8'h42, 8'h49, 8'h4B, 8'h46, 8'h47, 8'h4A,
            8'h45, 8'h44, 8'h4F, 8'h83, 8'hB0, 8'hB0, 8'hA2, 8'hB0, 8'h4C, 8'h83, 8'hB0};
        logic [15:0] trace [38] = '{
            16'h0000, 16'h0100, 16'h0205, 16'h0305, 16'h0405, 16'h0505, 16'h0600, 16'h0900,
            16'h0A00, 16'h0B3C, 16'h0C3C, 16'h0D00, 16'h0D00, 16'h0D00, 16'h0E00, 16'h0FFF,
            16'h10FF, 16'h11FF, 16'h12FF, 16'h13FF, 16'h14FF, 16'h15FE, 16'h1600, 16'h17FD,
            16'h18FE, 16'h1901, 16'h1A7F, 16'h1BFE, 16'h1CFE, 16'h1D00, 16'h1E00, 16'h1FFF,
            16'h2001, 16'h2100, 16'h2400, 16'h2600, 16'h27FF, 16'h28FF};
        for (int i = 0; i < 256; i++) rom[i] = 8'hB0;
        for (int i = 0; i < 41; i++) rom[i] = prog[i];
        #2;
        chk("rst_code_req", code_req, 1);
        chk("rst_code_addr", code_address, 0);
        chk("rst_data_req", data_req, 0);
        chk("rst_write", write, 0);
        chk("rst_ram_out", ram_out, 0);
        chk("rst_halted", halted, 0);
        for (int i = 0; i < 38; i++) fq.push_back(trace[i]);
        sq.push_back(16'h0005);
        sq.push_back(16'hFFFF);
        step();
        step();
        rst = 1'b1;
        code_ready = 1'b1;
        data_ready = 1'b1;
        chk("first_fetch", code_address, 0);
        step(); step();
        chk("fetch1_addr", code_address, 1);
        step(); step();
        chk("fetch2_addr", code_address, 2);
        step(); step();
        chk("str_data_req", data_req, 1);
        chk("str_write", write, 1);
        chk("str_ram_out", ram_out, 8'h05);
        chk("str_data_addr", data_address, 0);
        ram_in = 8'hFF;
        wait_fetch(8'h09);
        step();
        ram_in = 8'h3C;
        data_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("ldb_stall_req", data_req, 1);
            chk("ldb_stall_addr", data_address, 0);
            chk("ldb_stall_write", write, 0);
        end
        step();
        chk("ldb_last_req", data_req, 1);
        data_ready = 1'b1;
        step();
        chk("ldb_done_fetch", code_req, 1);
        chk("ldb_done_pc", code_address, 8'h0A);
        chk("ldb_done_req", data_req, 0);
        wait_fetch(8'h0D);
        step();
        chk("loop_exec", code_req, 0);
        step();
        chk("loop_refetch", code_address, 8'h0D);
        step();
        step();
        chk("loop_refetch2", code_address, 8'h0D);
        rom[13] = 8'h00;
        wait_fetch(8'h11);
        chk("d_wrap_add", data_address, 8'h01);
        wait_fetch(8'h12);
        chk("d_sub_add", data_address, 8'hFF);
        wait_fetch(8'h28);
        step();
        step();
        chk("hlt_halted", halted, 1);
        chk("hlt_code_req", code_req, 0);
        chk("hlt_data_req", data_req, 0);
        chk("hlt_pc", code_address, 8'h28);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("hlt_no_fetch", code_req, 0);
        end
        chk("run1_fetch_left", fq.size(), 0);
        chk("run1_store_left", sq.size(), 0);
        rst = 1'b0;
        code_ready = 1'b0;
        data_ready = 1'b0;
        #2;
        chk("rst2_halted", halted, 0);
        chk("rst2_code_req", code_req, 1);
        chk("rst2_data_addr", data_address, 0);
        chk("rst2_ram_out", ram_out, 0);
        step();
        fq.push_back(16'h0000);
        fq.push_back(16'h0100);
        fq.push_back(16'h0205);
        rst = 1'b1;
        code_ready = 1'b1;
        wait_fetch(8'h02);
        step();
        step();
        step();
        chk("mem_hold_req", data_req, 1);
        chk("mem_hold_write", write, 1);
        chk("mem_hold_r", ram_out, 8'h05);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_data_req", data_req, 0);
        chk("abort_write", write, 0);
        chk("abort_ram_out", ram_out, 0);
        chk("abort_code_req", code_req, 1);
        chk("abort_pc", code_address, 0);
        step();
        step();
        fq.push_back(16'h0000);
        rst = 1'b1;
        wait_fetch(8'h00);
        step();
        chk("run2_fetch_left", fq.size(), 0);
        chk("run2_store_left", sq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
